// File: rtl/hrdata_txfmt.sv
// Formats one AHB read word as uppercase ASCII hex (MSB nibble first, optional CR LF) and
// hands the characters one at a time to the COMM front end, with timeout/retry per byte.
module hrdata_txfmt #(
  parameter int unsigned DW        = 32,
  parameter int unsigned TERM_CRLF = 1,
  parameter int unsigned TO_CYC    = 16,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [DW-1:0] hrdata,
  input  logic          tx_idle,
  input  logic          tx_work,
  input  logic          cts,
  output logic          xfer,
  output logic [7:0]    data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned NIB    = DW / 4;
  localparam int unsigned NBYTES = NIB + 2 * TERM_CRLF;
  localparam int unsigned IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned TW     = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam int unsigned RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  // One spare bit so NIB itself is representable when NBYTES is a power of two.
  localparam logic [IW:0] NIB_W  = (IW + 1)'(NIB);

  typedef enum logic [1:0] {StIdle, StWaitIdle, StIssue, StWaitStart} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] word_q, word_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          done_d, err_d;
  logic          xfer_q;
  logic [7:0]    data_q;

  logic [DW-1:0] shifted;
  logic [3:0]    nib;
  logic [7:0]    char;

  // Character for the current idx; shifting left keeps the selected nibble at the top.
  always_comb begin
    shifted = word_q << {idx_q, 2'b00};
    nib     = shifted[DW-1 -: 4];
    if ({1'b0, idx_q} < NIB_W) begin
      char = (nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end else if ({1'b0, idx_q} == NIB_W) begin
      char = 8'h0D;
    end else begin
      char = 8'h0A;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          word_d  = hrdata;
          idx_d   = '0;
          retry_d = '0;
          state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (tx_idle && !cts) state_d = StIssue;
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitStart;
      end
      StWaitStart: begin
        cnt_d = cnt_q + 1'b1;
        if (tx_work) begin
          cnt_d = '0;
          if (idx_q == IW'(NBYTES - 1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            retry_d = '0;
            state_d = StWaitIdle;
          end
        end else if (cnt_q == TW'(TO_CYC - 1)) begin
          cnt_d = '0;
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = StWaitIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      retry_q <= '0;
      xfer_q  <= 1'b0;
      data_q  <= 8'h00;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      xfer_q  <= (state_d == StIssue);
      if (state_d == StIssue) data_q <= char;
      done    <= done_d;
      err     <= err_d;
    end
  end

  assign xfer = xfer_q;
  assign data = data_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_hrdata_txfmt.sv
// Directed bench for hrdata_txfmt: a CRLF build and a no-CRLF build share one stimulus.
module tb_hrdata_txfmt;

  localparam int unsigned TO_CYC   = 16;
  localparam int unsigned IDLE_CYC = 100;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        load = 1'b0;
  logic [31:0] hrdata = '0;
  logic        tx_idle = 1'b1;
  logic        tx_work = 1'b0;
  logic        cts = 1'b0;
  logic        xfer, busy, done, err;
  logic [7:0]  data;
  logic        xfer8, busy8, done8, err8;
  logic [7:0]  data8;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_dead [10] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46,
                                8'h0D, 8'h0A};
  logic [7:0] exp_dig  [10] = '{8'h30, 8'h39, 8'h41, 8'h46, 8'h31, 8'h32, 8'h33, 8'h30,
                                8'h0D, 8'h0A};

  always #5 clk = ~clk;

  hrdata_txfmt #(.DW(32), .TERM_CRLF(1), .TO_CYC(TO_CYC), .MAX_RETRY(3)) u_dut (
    .clk(clk), .rstn(rstn), .load(load), .hrdata(hrdata), .tx_idle(tx_idle),
    .tx_work(tx_work), .cts(cts), .xfer(xfer), .data(data), .busy(busy), .done(done),
    .err(err)
  );

  hrdata_txfmt #(.DW(32), .TERM_CRLF(0), .TO_CYC(TO_CYC), .MAX_RETRY(3)) u_dut8 (
    .clk(clk), .rstn(rstn), .load(load), .hrdata(hrdata), .tx_idle(tx_idle),
    .tx_work(tx_work), .cts(cts), .xfer(xfer8), .data(data8), .busy(busy8), .done(done8),
    .err(err8)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; load = 1'b0; tx_idle = 1'b1; tx_work = 1'b0; cts = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic do_load(input logic [31:0] w);
    hrdata = w;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  // Front-end model for one byte: tx_work two cycles after xfer, then UART busy IDLE_CYC.
  task automatic run_byte(input logic [7:0] exp, input bit last, input bit use8,
                          input bit last8, input bit poke, input string tag);
    int n;
    n = 0;
    while (xfer !== 1'b1 && n < 300) begin tick(); n++; end
    check({tag, " xfer"}, xfer, 1);
    check({tag, " data"}, data, exp);
    if (use8) begin
      check({tag, " xfer8"}, xfer8, 1);
      check({tag, " data8"}, data8, exp);
    end
    tick();
    check({tag, " xfer single"}, xfer, 0);
    tick();
    tx_work = 1'b1; tx_idle = 1'b0;
    tick();
    tx_work = 1'b0;
    check({tag, " done"}, done, last);
    check({tag, " busy"}, busy, !last);
    if (use8) check({tag, " done8"}, done8, last8);
    if (poke) begin
      // Second load and a stray tx_work while waiting for the UART must change nothing.
      repeat (10) tick();
      hrdata = 32'h1111_1111; load = 1'b1;
      tick();
      load = 1'b0; tx_work = 1'b1;
      tick();
      tx_work = 1'b0;
    end
    repeat (IDLE_CYC) tick();
    tx_idle = 1'b1;
  endtask

  initial begin
    int n;
    bit seen;

    tick();
    check("reset xfer", xfer, 0);
    check("reset data", data, 8'h00);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    rstn = 1'b1;
    tick();

    // Basic word with load-to-xfer latency.
    do_load(32'hDEAD_BEEF);
    check("basic busy after load", busy, 1);
    check("basic xfer t+1", xfer, 0);
    tick();
    check("basic xfer t+2", xfer, 1);
    for (int i = 0; i < 10; i++) run_byte(exp_dead[i], i == 9, 1'b0, 1'b0, 1'b0, "basic");

    // Digit boundaries, also through the no-CRLF build.
    do_reset();
    do_load(32'h09AF_1230);
    for (int i = 0; i < 10; i++) run_byte(exp_dig[i], i == 9, i < 8, i == 7, 1'b0, "digit");
    check("digit busy8 after 8", busy8, 0);

    // Collision and spurious tx_work during byte 2's wait.
    do_reset();
    do_load(32'hDEAD_BEEF);
    for (int i = 0; i < 10; i++) run_byte(exp_dead[i], i == 9, 1'b0, 1'b0, i == 2, "collide");

    // cts hold.
    do_reset();
    cts = 1'b1;
    do_load(32'hDEAD_BEEF);
    seen = 1'b0;
    repeat (500) begin tick(); if (xfer || err) seen = 1'b1; end
    check("hold no xfer/err", seen, 0);
    check("hold busy", busy, 1);
    cts = 1'b0;
    n = 0;
    while (xfer !== 1'b1 && n < 2) begin tick(); n++; end
    check("hold release xfer", xfer, 1);
    check("hold release data", data, 8'h44);

    // Lost byte: no tx_work ever.
    do_reset();
    do_load(32'hDEAD_BEEF);
    n = 0;
    while (xfer !== 1'b1 && n < 5) begin tick(); n++; end
    for (int k = 0; k < 4; k++) begin
      check("lost xfer", xfer, 1);
      check("lost data", data, 8'h44);
      if (k < 3) begin
        tick();
        n = 1;
        while (xfer !== 1'b1 && n < 40) begin tick(); n++; end
        check("lost gap", n, TO_CYC + 2);
      end
    end
    repeat (TO_CYC + 1) tick();
    check("lost err", err, 1);
    check("lost busy", busy, 0);
    check("lost done", done, 0);
    tick();
    check("lost err pulse", err, 0);
    seen = 1'b0;
    repeat (40) begin tick(); if (xfer || done) seen = 1'b1; end
    check("lost quiet", seen, 0);

    // Reset in the middle of the 4th byte.
    do_reset();
    do_load(32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) run_byte(exp_dead[i], 1'b0, 1'b0, 1'b0, 1'b0, "rst");
    n = 0;
    while (xfer !== 1'b1 && n < 10) begin tick(); n++; end
    check("rst 4th xfer", xfer, 1);
    rstn = 1'b0;
    #1;
    check("rst xfer", xfer, 0);
    check("rst data", data, 8'h00);
    check("rst busy", busy, 0);
    tick(); tick();
    check("rst done", done, 0);
    check("rst err", err, 0);
    rstn = 1'b1;
    tick();
    do_load(32'hDEAD_BEEF);
    run_byte(8'h44, 1'b0, 1'b0, 1'b0, 1'b0, "rst restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
